dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two.
REQ-002 Parameter LAT, default 2: access latency in cycles; legal range 1..15.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-low.
REQ-005 Port req_valid  input  1  the MEMORY stage presents a request.
REQ-006 Port req_ready  output  1  the block accepts a request this cycle.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_wdata  input  32  store data.
REQ-010 Port req_be  input  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-011 Port rsp_valid  output  1  the response is present.
REQ-012 Port rsp_ready  input  1  the requester takes the response.
REQ-013 Port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 Port rsp_err  output  1  misaligned or out-of-range access.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE, so there are no back-to-back accepts.
REQ-017 A request SHALL be accepted at a rising edge where req_valid=1 and req_ready=1; addr, we, wdata and be SHALL be latched at that edge.
REQ-018 On accept, the FSM SHALL load a latency counter with LAT-1. If LAT=1 it SHALL go to RESP; otherwise it SHALL go to WAIT.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
REQ-020 rsp_valid SHALL rise exactly LAT cycles after the accept edge.
REQ-021 The array access (store commit or load capture) SHALL occur on the edge entering RESP.
REQ-022 An error SHALL be raised when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; the error SHALL be decided from the latched address.
REQ-023 For an errored access: no array write, rsp_err=1, rsp_rdata=0.
REQ-024 A store SHALL update only the bytes whose enable is 1; be=0000 is a legal no-op store that completes with rsp_err=0.
REQ-025 A load SHALL return the full word and ignore be.
REQ-026 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge where rsp_ready=1; at that edge the FSM SHALL go to IDLE.
REQ-027 rsp_ready=1 while rsp_valid=0 SHALL have no effect.
REQ-028 req_valid asserted outside IDLE SHALL be ignored and not queued.
REQ-029 A load from the address of the immediately preceding completed store SHALL return the stored data; no stale bypass is permitted.
REQ-030 Minimum request-to-request spacing SHALL be LAT+1 cycles when rsp_ready is held at 1.

Reset
REQ-031 When rst=0 at a rising edge, the FSM SHALL go to IDLE, the counter SHALL go to 0, and rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready SHALL be 1 from the first edge with rst=1.
REQ-032 Reset in WAIT SHALL drop the pending store uncommitted.
REQ-033 Reset in RESP SHALL discard the response.
REQ-034 Array contents SHALL NOT be cleared by reset.

Structure
REQ-035 The shared package cpu_pkg SHALL hold the FSM state enum, the default DEPTH_WORDS and LAT values, and the word-width constant (32).
REQ-036 Storage SHALL be a sub-module dmem_array: synchronous read, per-byte write enable, one port.
REQ-037 dmem_responder SHALL contain only the FSM, the counter, the request latches and the error check.

Verification
REQ-038 Store addr=0x10, wdata=0xDEADBEEF, be=1111, then load 0x10 -> rdata=0xDEADBEEF, err=0; rsp_valid rises 2 cycles after each accept.
REQ-039 Store 0x10, be=0010, wdata=0x0000AA00, over 0xDEADBEEF, then load 0x10 -> rdata=0xDEADAAEF.
REQ-040 Load addr=0x13 and load addr=0x400 (DEPTH_WORDS=256) -> err=1, rdata=0 for both; a following load of 0x10 is unchanged.
REQ-041 Hold rsp_ready=0 for 5 cycles in RESP with req_valid=1 -> rsp outputs stable, req_ready=0, no second accept; accept occurs the cycle after the handshake.
REQ-042 Store 0x20 with 0x12345678, assert rst=0 in WAIT, release, load 0x20 -> prior contents returned; rsp_valid=0 and req_ready=1 right after reset.
REQ-043 With LAT=1 and rsp_ready tied to 1, issue 4 loads -> accepts exactly every 2 cycles, each rsp_valid 1 cycle after its accept.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory responder slice.
// Holds the word width, default geometry/latency, the responder FSM state type and the
// access-error check used by the responder.
package cpu_pkg;

  localparam int unsigned WordW         = 32;
  localparam int unsigned DefDepthWords = 256;
  localparam int unsigned DefLat        = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // A word access is illegal when misaligned or beyond the last stored word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with synchronous read and per-byte write enables.
// Ports:
//   clk    - clock
//   en     - perform an access this edge
//   we     - 1 = write the enabled bytes, 0 = capture the word into rdata
//   be     - byte enables for writes (bit i covers wdata[8i+7:8i])
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read data, held until the next read
// Contents are never reset.
module dmem_array
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DefDepthWords,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [AW-1:0]    addr,
  input  logic [WordW-1:0] wdata,
  output logic [WordW-1:0] rdata
);

  logic [WordW-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEMORY stage.
// Accepts one request in IDLE, waits LAT cycles, then presents a response until it is taken.
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   req_valid/req_ready           - request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata, req_be - request fields, latched on accept
//   rsp_valid/rsp_ready           - response handshake
//   rsp_rdata, rsp_err            - load data (0 for stores/errors), error flag
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DefDepthWords,
  parameter int unsigned LAT         = DefLat
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [WordW-1:0] req_wdata,
  input  logic [3:0]       req_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WordW-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q;
  logic [3:0]       be_q;
  logic [31:0]      addr_q;
  logic [WordW-1:0] wdata_q;
  logic             accept, access;

  logic             acc_sel, acc_we;
  logic [3:0]       acc_be;
  logic [31:0]      acc_addr;
  logic [WordW-1:0] acc_wdata;
  logic             arr_en;
  logic [WordW-1:0] arr_rdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = 4'(LAT - 1);
          if (LAT == 1) begin
            state_d = StResp;
            access  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Enter RESP on the edge where the counter reaches zero.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = StResp;
          access  = 1'b1;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      be_q    <= req_be;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // With LAT=1 the array is accessed on the accept edge itself, before the latches
  // hold the request, so the live request fields are used in that case.
  assign acc_sel   = (state_q == StIdle);
  assign acc_we    = acc_sel ? req_we    : we_q;
  assign acc_be    = acc_sel ? req_be    : be_q;
  assign acc_addr  = acc_sel ? req_addr  : addr_q;
  assign acc_wdata = acc_sel ? req_wdata : wdata_q;

  // Gating with rst drops a pending store when reset lands on the commit edge.
  assign arr_en = access && rst && !addr_err(acc_addr, DEPTH_WORDS);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (acc_we),
    .be   (acc_be),
    .addr (acc_addr[AW+1:2]),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  assign rsp_err   = rsp_valid && addr_err(addr_q, DEPTH_WORDS);
  assign rsp_rdata = (rsp_valid && !we_q && !rsp_err) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LAT=2 instance plus a LAT=1 instance).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid1, req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(1'b0),
    .req_addr(32'h10), .req_wdata(32'h0), .req_be(4'hF),
    .rsp_valid(rsp_valid1), .rsp_ready(1'b1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for its response; lat is the cycle (1 = the cycle right
  // after the accept edge) in which rsp_valid first appears. Response is taken at once.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    if (!rsp_valid) begin
      tests++; fails++;
      $display("FAIL rsp_timeout addr=%h: no rsp_valid within 20 cycles", addr);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    tests++; if (req_ready1 !== 1'b1) begin fails++; $display("FAIL reset_req_ready_lat1 got=%b exp=1", req_ready1); end
    // rsp_ready while idle must do nothing
    rsp_ready = 1'b1;
    step(); step();
    rsp_ready = 1'b0;
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL idle_rsp_ready got ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] d; logic e; int l;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, l);
    tests++; if (e !== 1'b0 || d !== 32'h0) begin fails++; $display("FAIL store_rsp got err=%b rdata=%h exp err=0 rdata=0", e, d); end
    tests++; if (l != 2) begin fails++; $display("FAIL store_latency got=%0d exp=2", l); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, d, e, l);
    tests++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin fails++; $display("FAIL load_full got rdata=%h err=%b exp rdata=deadbeef err=0", d, e); end
    tests++; if (l != 2) begin fails++; $display("FAIL load_latency got=%0d exp=2", l); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d; logic e; int l;
    do_req(1'b1, 32'h10, 32'h0000AA00, 4'b0010, d, e, l);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, d, e, l);
    tests++; if (d !== 32'hDEADAAEF) begin fails++; $display("FAIL byte_merge got=%h exp=deadaaef", d); end
    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, d, e, l);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL noop_store_err got=%b exp=0", e); end
    do_req(1'b0, 32'h10, 32'h0, 4'b0000, d, e, l);
    tests++; if (d !== 32'hDEADAAEF) begin fails++; $display("FAIL noop_store_data got=%h exp=deadaaef", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int l;
    do_req(1'b1, 32'h0, 32'h11112222, 4'hF, d, e, l);
    do_req(1'b0, 32'h13, 32'h0, 4'hF, d, e, l);
    tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL misaligned got err=%b rdata=%h exp err=1 rdata=0", e, d); end
    do_req(1'b0, 32'h400, 32'h0, 4'hF, d, e, l);
    tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL out_of_range got err=%b rdata=%h exp err=1 rdata=0", e, d); end
    // 0x400 would alias word 0 if the error did not block the write
    do_req(1'b1, 32'h400, 32'h55555555, 4'hF, d, e, l);
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL oor_store_err got=%b exp=1", e); end
    do_req(1'b0, 32'h0, 32'h0, 4'hF, d, e, l);
    tests++; if (d !== 32'h11112222) begin fails++; $display("FAIL oor_store_alias got=%h exp=11112222", d); end
    do_req(1'b0, 32'h10, 32'h0, 4'hF, d, e, l);
    tests++; if (d !== 32'hDEADAAEF || e !== 1'b0) begin fails++; $display("FAIL after_err_load got rdata=%h err=%b exp deadaaef/0", d, e); end
    do_req(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, d, e, l);
    do_req(1'b0, 32'h3FC, 32'h0, 4'hF, d, e, l);
    tests++; if (d !== 32'hCAFEF00D || e !== 1'b0) begin fails++; $display("FAIL last_word got rdata=%h err=%b exp cafef00d/0", d, e); end
  endtask

  task automatic test_backpressure();
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF;
    step();
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADAAEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_cycle%0d got valid=%b rdata=%h err=%b ready=%b exp 1/deadaaef/0/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL handshake got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
    step();
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL accept_after_handshake got ready=%b exp=0", req_ready); end
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    tests++; if (rsp_rdata !== 32'hDEADAAEF) begin fails++; $display("FAIL second_load got=%h exp=deadaaef", rsp_rdata); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int l;
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, d, e, l);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    step();
    req_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL reset_in_wait got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
    step();
    do_req(1'b0, 32'h20, 32'h0, 4'hF, d, e, l);
    tests++; if (d !== 32'hAABBCCDD) begin fails++; $display("FAIL dropped_store got=%h exp=aabbccdd", d); end
    // reset while a response is pending discards it
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    tests++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_in_resp got valid=%b rdata=%h exp 0/0", rsp_valid, rsp_rdata); end
    step();
  endtask

  task automatic test_lat1();
    int accepts;
    logic acc;
    accepts = 0;
    req_valid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc = req_ready1;
      step();
      if (acc) accepts++;
      tests++;
      if (rsp_valid1 !== ((i % 2) == 0) || req_ready1 !== ((i % 2) == 1)) begin
        fails++;
        $display("FAIL lat1_edge%0d got valid=%b ready=%b exp valid=%b ready=%b",
                 i, rsp_valid1, req_ready1, (i % 2) == 0, (i % 2) == 1);
      end
    end
    req_valid1 = 1'b0;
    tests++; if (accepts != 4) begin fails++; $display("FAIL lat1_accepts got=%0d exp=4", accepts); end
    tests++; if (rsp_err1 !== 1'b0) begin fails++; $display("FAIL lat1_err got=%b exp=0", rsp_err1); end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0; req_valid1 = 1'b0;
    #1;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_lat1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
